// File: rtl/ofdm_cp_remove_if.sv
// Sample-stream and FFT-burst signal bundle of ofdm_cp_remove.
// master drives the input stream and flag_wayt_data; slave is the CP remover.
interface ofdm_cp_remove_if #(
    parameter int DATA_FFT_SIZE = 16
);
    logic                     in_valid;
    logic                     in_sof;
    logic [DATA_FFT_SIZE-1:0] data_in_i;
    logic [DATA_FFT_SIZE-1:0] data_in_q;
    logic                     flag_wayt_data;
    logic                     valid;
    logic [DATA_FFT_SIZE-1:0] data_out_i;
    logic [DATA_FFT_SIZE-1:0] data_out_q;
    logic                     overflow;
    logic                     resync;

    modport master (
        output in_valid, in_sof, data_in_i, data_in_q, flag_wayt_data,
        input  valid, data_out_i, data_out_q, overflow, resync
    );

    modport slave (
        input  in_valid, in_sof, data_in_i, data_in_q, flag_wayt_data,
        output valid, data_out_i, data_out_q, overflow, resync
    );
endinterface

// File: rtl/ofdm_cp_remove.sv
// OFDM cyclic-prefix remover with a ping-pong symbol buffer feeding myFFT as gap-free bursts.
// Optional `CPR_SOF_RESYNC_EN: an in_sof inside a partial symbol abandons it and pulses resync.
module ofdm_cp_remove #(
    parameter int SIZE_BUFFER   = 8,
    parameter int DATA_FFT_SIZE = 16,
    parameter int CP_LEN        = 32
) (
    input  logic            clk,
    input  logic            reset,
    ofdm_cp_remove_if.slave bus
);
    localparam int NFFT = 2 ** SIZE_BUFFER;
    localparam int AW   = SIZE_BUFFER;
    localparam int DW   = 2 * DATA_FFT_SIZE;

    localparam logic [AW-1:0] CP_LAST   = AW'(CP_LEN - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NFFT - 1);

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_CP    = 2'd1;
    localparam logic [1:0] W_DATA  = 2'd2;
    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_BURST = 1'b1;

`ifdef CPR_SOF_RESYNC_EN
    localparam bit RESYNC_EN = 1'b1;
`else
    localparam bit RESYNC_EN = 1'b0;
`endif

    // Bank A occupies addresses 0..NFFT-1, bank B NFFT..2*NFFT-1.
    logic [DW-1:0] mem [0:2*NFFT-1];

    logic [1:0]    full, full_free, wr_set, rd_clr;
    logic [1:0]    w_state, w_state_nxt;
    logic [AW-1:0] wcnt, wcnt_nxt;
    logic          wbank, wbank_nxt;
    logic          wdrop, wdrop_nxt;
    logic          wr_en, sof_start, enter_data, abort;
    logic          ovf_nxt, ovf_q;

    logic [0:0]               r_state;
    logic [AW-1:0]            raddr;
    logic                     rbank;
    logic                     valid_q;
    logic [DATA_FFT_SIZE-1:0] dout_i, dout_q;

    // A bank released by the last read of a burst is already free to the writer that cycle.
    assign rd_clr    = (r_state == R_BURST && raddr == ADDR_LAST) ? (2'b01 << rbank) : 2'b00;
    assign full_free = full & ~rd_clr;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and infers a latch.
        w_state_nxt = w_state;
        wcnt_nxt    = wcnt;
        wbank_nxt   = wbank;
        wdrop_nxt   = wdrop;
        wr_en       = 1'b0;
        wr_set      = 2'b00;
        ovf_nxt     = 1'b0;
        sof_start   = 1'b0;
        enter_data  = 1'b0;
        abort       = 1'b0;
        if (bus.in_valid) begin
            case (w_state)
                W_IDLE: sof_start = bus.in_sof;
                W_CP: begin
                    if (RESYNC_EN && bus.in_sof) abort = 1'b1;
                    else if (wcnt == CP_LAST)    enter_data = 1'b1;
                    else                         wcnt_nxt = wcnt + 1'b1;
                end
                W_DATA: begin
                    wr_en = !wdrop;
                    if (wcnt == ADDR_LAST) begin
                        if (wdrop) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            wr_set[wbank] = 1'b1;
                            wbank_nxt     = ~wbank;
                        end
                        w_state_nxt = W_IDLE;
                        sof_start   = bus.in_sof;
                    end else if (RESYNC_EN && bus.in_sof) begin
                        abort = 1'b1;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
                default: w_state_nxt = W_IDLE;
            endcase
        end
        if (abort) sof_start = 1'b1;
        // The SOF sample itself is CP sample 0.
        if (sof_start) begin
            if (CP_LEN == 1) begin
                enter_data = 1'b1;
            end else begin
                w_state_nxt = W_CP;
                wcnt_nxt    = AW'(1);
            end
        end
        if (enter_data) begin
            w_state_nxt = W_DATA;
            wcnt_nxt    = '0;
            wdrop_nxt   = full_free[wbank_nxt];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            w_state <= W_IDLE;
            wcnt    <= '0;
            wbank   <= 1'b0;
            wdrop   <= 1'b0;
            full    <= 2'b00;
            ovf_q   <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            wcnt    <= wcnt_nxt;
            wbank   <= wbank_nxt;
            wdrop   <= wdrop_nxt;
            full    <= full_free | wr_set;
            ovf_q   <= ovf_nxt;
        end
    end

    // NOTE: the sample RAM is deliberately not reset; the full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[{wbank, wcnt}] <= {bus.data_in_i, bus.data_in_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            raddr   <= '0;
            rbank   <= 1'b0;
            valid_q <= 1'b0;
            dout_i  <= '0;
            dout_q  <= '0;
        end else begin
            valid_q <= (r_state == R_BURST);
            case (r_state)
                R_IDLE: begin
                    if (full[rbank] && bus.flag_wayt_data) begin
                        r_state <= R_BURST;
                        raddr   <= '0;
                    end
                end
                default: begin
                    {dout_i, dout_q} <= mem[{rbank, raddr}];
                    raddr            <= raddr + 1'b1;
                    if (raddr == ADDR_LAST) begin
                        r_state <= R_IDLE;
                        rbank   <= ~rbank;
                    end
                end
            endcase
        end
    end

    assign bus.valid      = valid_q;
    assign bus.data_out_i = dout_i;
    assign bus.data_out_q = dout_q;
    assign bus.overflow   = ovf_q;

`ifdef CPR_SOF_RESYNC_EN
    logic rsy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rsy_q <= 1'b0;
        else       rsy_q <= abort;
    end

    assign bus.resync = rsy_q;
`else
    assign bus.resync = 1'b0;
`endif
endmodule

// File: tb/tb_ofdm_cp_remove.sv
// Self-checking bench for ofdm_cp_remove: random sample streams against a stream-position model.
// Expected payload of a symbol is simply stream[sof_index + CP .. sof_index + CP + NFFT - 1].
module tb_ofdm_cp_remove;
    localparam int SB  = 8;
    localparam int W   = 16;
    localparam int CP  = 32;
    localparam int N   = 2 ** SB;
    localparam int SYM = CP + N;

    typedef struct packed {
        logic         sof;
        logic [W-1:0] i;
        logic [W-1:0] q;
    } samp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ofdm_cp_remove_if #(.DATA_FFT_SIZE(W)) bus ();

    ofdm_cp_remove #(.SIZE_BUFFER(SB), .DATA_FFT_SIZE(W), .CP_LEN(CP)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;
    int cur_len  = 0;
    logic prev_valid = 1'b0;

    samp_t          stim_q[$];
    int             acc_q[$];
    logic [2*W-1:0] got_q[$];
    logic [2*W-1:0] exp_q[$];
    int             start_q[$];
    int             len_q[$];
    int             ovf_q[$];
    int             rsy_q[$];

    // Output monitor: samples 1 time unit after each rising edge; cyc = edges seen so far.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.valid === 1'b1) begin
            if (!prev_valid) start_q.push_back(cyc);
            got_q.push_back({bus.data_out_i, bus.data_out_q});
            cur_len++;
        end else if (prev_valid) begin
            len_q.push_back(cur_len);
            cur_len = 0;
        end
        prev_valid = (bus.valid === 1'b1);
        if (bus.overflow === 1'b1) ovf_q.push_back(cyc);
        if (bus.resync === 1'b1)   rsy_q.push_back(cyc);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time got %0t want below 900000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic clear_mon();
        got_q.delete(); exp_q.delete(); start_q.delete();
        len_q.delete(); ovf_q.delete(); rsy_q.delete();
    endtask

    task automatic drive(input logic v, input logic sof, input logic [W-1:0] i, input logic [W-1:0] q);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sof    = sof;
        bus.data_in_i = i;
        bus.data_in_q = q;
        if (v) last_acc = cyc + 1;
    endtask

    function automatic void add_symbol(input int len, input bit rnd, input bit first_sof);
        for (int k = 0; k < len; k++) begin
            samp_t s;
            s.sof = first_sof && (k == 0);
            s.i   = rnd ? W'($urandom) : W'(k);
            s.q   = rnd ? W'($urandom) : ~W'(k);
            stim_q.push_back(s);
        end
    endfunction

    function automatic void push_exp(input int sof_idx);
        for (int k = 0; k < N; k++)
            exp_q.push_back({stim_q[sof_idx + CP + k].i, stim_q[sof_idx + CP + k].q});
    endfunction

    // Idle gaps carry random in_sof/data to confirm they are ignored without in_valid.
    task automatic send_stream(input bit gaps);
        acc_q.delete();
        foreach (stim_q[k]) begin
            if (gaps && $urandom_range(0, 7) == 0)
                drive(1'b0, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
            drive(1'b1, stim_q[k].sof, stim_q[k].i, stim_q[k].q);
            acc_q.push_back(last_acc);
        end
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_bursts(input int n, input int budget);
        int t = 0;
        while (len_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    function automatic int data_mismatch();
        int n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            if (k >= got_q.size() || k >= exp_q.size()) return k;
            if (got_q[k] !== exp_q[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [2*W-1:0] got_at(input int k);
        return (k < got_q.size()) ? got_q[k] : 'x;
    endfunction

    function automatic logic [2*W-1:0] exp_at(input int k);
        return (k < exp_q.size()) ? exp_q[k] : 'x;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0;
        bus.data_in_i = '0; bus.data_in_q = '0; bus.flag_wayt_data = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        n_checks++; if (bus.data_out_i !== '0) begin n_fail++; $display("FAIL reset_data_i: got %h want 0", bus.data_out_i); end
        n_checks++; if (bus.data_out_q !== '0) begin n_fail++; $display("FAIL reset_data_q: got %h want 0", bus.data_out_q); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        n_checks++; if (bus.resync !== 1'b0) begin n_fail++; $display("FAIL reset_resync: got %b want 0", bus.resync); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", bus.valid); end
        clear_mon();
    endtask

    task automatic test_single_symbol();
        int m;
        clear_mon();
        bus.flag_wayt_data = 1'b1;
        stim_q.delete();
        add_symbol(SYM, 1'b0, 1'b1);
        push_exp(0);
        send_stream(1'b0);
        wait_bursts(1, 3 * N);
        n_checks++;
        if (len_q.size() != 1 || len_q[0] != N) begin
            n_fail++; $display("FAIL single_len: got %0d bursts, first len %0d, want 1 of %0d",
                               len_q.size(), (len_q.size() > 0) ? len_q[0] : -1, N);
        end
        n_checks++;
        if (start_q.size() == 0 || start_q[0] != acc_q[SYM-1] + 2) begin
            n_fail++; $display("FAIL single_latency: got start %0d want %0d",
                               (start_q.size() > 0) ? start_q[0] : -1, acc_q[SYM-1] + 2);
        end
        m = data_mismatch();
        n_checks++;
        if (m >= 0) begin
            n_fail++; $display("FAIL single_data: sample %0d got %h want %h (%0d vs %0d samples)",
                               m, got_at(m), exp_at(m), got_q.size(), exp_q.size());
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.data_out_i !== stim_q[SYM-1].i || bus.data_out_q !== stim_q[SYM-1].q) begin
            n_fail++; $display("FAIL single_hold: got %h/%h want %h/%h", bus.data_out_i, bus.data_out_q,
                               stim_q[SYM-1].i, stim_q[SYM-1].q);
        end
        n_checks++;
        if (ovf_q.size() != 0) begin n_fail++; $display("FAIL single_overflow: got %0d pulses want 0", ovf_q.size()); end
    endtask

    task automatic test_back_pressure();
        int t, m;
        clear_mon();
        bus.flag_wayt_data = 1'b0;
        stim_q.delete();
        add_symbol(SYM, 1'b1, 1'b1);
        push_exp(0);
        send_stream(1'b1);
        repeat (100) @(negedge clk);
        n_checks++;
        if (start_q.size() != 0) begin n_fail++; $display("FAIL bp_hold: got %0d bursts want 0", start_q.size()); end
        @(negedge clk);
        t = cyc;
        bus.flag_wayt_data = 1'b1;
        wait_bursts(1, 3 * N);
        n_checks++;
        if (start_q.size() == 0 || start_q[0] != t + 2) begin
            n_fail++; $display("FAIL bp_start: got %0d want %0d", (start_q.size() > 0) ? start_q[0] : -1, t + 2);
        end
        n_checks++;
        if (len_q.size() != 1 || len_q[0] != N) begin
            n_fail++; $display("FAIL bp_len: got %0d want %0d", (len_q.size() > 0) ? len_q[0] : -1, N);
        end
        m = data_mismatch();
        n_checks++;
        if (m >= 0) begin
            n_fail++; $display("FAIL bp_data: sample %0d got %h want %h", m, got_at(m), exp_at(m));
        end
    endtask

    task automatic test_overflow();
        int m;
        clear_mon();
        bus.flag_wayt_data = 1'b0;
        stim_q.delete();
        for (int s = 0; s < 3; s++) add_symbol(SYM, 1'b1, 1'b1);
        push_exp(0);
        push_exp(SYM);
        send_stream(1'b1);
        repeat (20) @(negedge clk);
        n_checks++;
        if (ovf_q.size() != 1 || ovf_q[0] != acc_q[3*SYM-1]) begin
            n_fail++; $display("FAIL ovf_pulse: got %0d pulses first at %0d want 1 at %0d",
                               ovf_q.size(), (ovf_q.size() > 0) ? ovf_q[0] : -1, acc_q[3*SYM-1]);
        end
        n_checks++;
        if (start_q.size() != 0) begin n_fail++; $display("FAIL ovf_hold: got %0d bursts want 0", start_q.size()); end
        bus.flag_wayt_data = 1'b1;
        wait_bursts(2, 4 * N);
        repeat (20) @(negedge clk);
        n_checks++;
        if (len_q.size() != 2 || len_q[0] != N || len_q[1] != N) begin
            n_fail++; $display("FAIL ovf_bursts: got %0d bursts want 2 of %0d", len_q.size(), N);
        end
        n_checks++;
        if (start_q.size() < 2 || start_q[1] - start_q[0] != N + 1) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d want %0d",
                               (start_q.size() > 1) ? start_q[1] - start_q[0] : -1, N + 1);
        end
        m = data_mismatch();
        n_checks++;
        if (m >= 0) begin
            n_fail++; $display("FAIL ovf_data: sample %0d got %h want %h", m, got_at(m), exp_at(m));
        end
    endtask

    // Symbol 2's SOF rides on symbol 1's last data sample; flag drops 10 cycles into burst 1.
    task automatic test_mid_burst_deassert();
        samp_t tmp;
        int m;
        clear_mon();
        bus.flag_wayt_data = 1'b1;
        stim_q.delete();
        add_symbol(SYM, 1'b1, 1'b1);
        tmp = stim_q[SYM-1];
        tmp.sof = 1'b1;
        stim_q[SYM-1] = tmp;
        add_symbol(SYM - 1, 1'b1, 1'b0);
        push_exp(0);
        push_exp(SYM - 1);
        fork
            send_stream(1'b1);
            begin
                int t = 0;
                while (start_q.size() == 0 && t < 4 * SYM) begin
                    @(negedge clk);
                    t++;
                end
                repeat (10) @(negedge clk);
                bus.flag_wayt_data = 1'b0;
            end
        join
        repeat (N + 50) @(negedge clk);
        n_checks++;
        if (len_q.size() != 1 || len_q[0] != N) begin
            n_fail++; $display("FAIL mid_len: got %0d bursts first len %0d want 1 of %0d",
                               len_q.size(), (len_q.size() > 0) ? len_q[0] : -1, N);
        end
        bus.flag_wayt_data = 1'b1;
        wait_bursts(2, 3 * N);
        n_checks++;
        if (len_q.size() != 2 || len_q[1] != N) begin
            n_fail++; $display("FAIL sof_on_last_len: got %0d bursts want 2", len_q.size());
        end
        m = data_mismatch();
        n_checks++;
        if (m >= 0) begin
            n_fail++; $display("FAIL mid_data: sample %0d got %h want %h", m, got_at(m), exp_at(m));
        end
    endtask

    task automatic test_resync();
        int m;
        clear_mon();
        bus.flag_wayt_data = 1'b1;
        stim_q.delete();
        add_symbol(100, 1'b1, 1'b1);
        add_symbol(SYM, 1'b1, 1'b1);
`ifdef CPR_SOF_RESYNC_EN
        push_exp(100);
`else
        push_exp(0);
`endif
        send_stream(1'b1);
        wait_bursts(1, 3 * N);
        repeat (N + 20) @(negedge clk);
        n_checks++;
        if (len_q.size() != 1 || len_q[0] != N) begin
            n_fail++; $display("FAIL resync_bursts: got %0d bursts want 1 of %0d", len_q.size(), N);
        end
        m = data_mismatch();
        n_checks++;
        if (m >= 0) begin
            n_fail++; $display("FAIL resync_data: sample %0d got %h want %h", m, got_at(m), exp_at(m));
        end
`ifdef CPR_SOF_RESYNC_EN
        n_checks++;
        if (rsy_q.size() != 1 || rsy_q[0] != acc_q[100]) begin
            n_fail++; $display("FAIL resync_pulse: got %0d pulses first at %0d want 1 at %0d",
                               rsy_q.size(), (rsy_q.size() > 0) ? rsy_q[0] : -1, acc_q[100]);
        end
`else
        n_checks++;
        if (rsy_q.size() != 0) begin n_fail++; $display("FAIL resync_pulse: got %0d pulses want 0", rsy_q.size()); end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int t, m;
        clear_mon();
        bus.flag_wayt_data = 1'b0;
        stim_q.delete();
        add_symbol(SYM, 1'b1, 1'b1);
        add_symbol(SYM, 1'b1, 1'b1);
        send_stream(1'b1);
        repeat (5) @(negedge clk);
        bus.flag_wayt_data = 1'b1;
        t = 0;
        while (start_q.size() == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (49) @(negedge clk);
        n_checks++;
        if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", bus.valid); end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.valid !== 1'b0 || bus.data_out_i !== '0) begin
            n_fail++; $display("FAIL rst_async: got valid %b data_i %h want 0/0", bus.valid, bus.data_out_i);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        clear_mon();
        repeat (2 * N + 20) @(negedge clk);
        n_checks++;
        if (start_q.size() != 0) begin n_fail++; $display("FAIL rst_no_burst: got %0d bursts want 0", start_q.size()); end
        stim_q.delete();
        add_symbol(SYM, 1'b1, 1'b1);
        push_exp(0);
        send_stream(1'b1);
        wait_bursts(1, 3 * N);
        n_checks++;
        if (start_q.size() != 1 || start_q[0] != acc_q[SYM-1] + 2 || len_q.size() != 1 || len_q[0] != N) begin
            n_fail++; $display("FAIL rst_recover: got %0d bursts start %0d want 1 at %0d",
                               start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, acc_q[SYM-1] + 2);
        end
        m = data_mismatch();
        n_checks++;
        if (m >= 0) begin
            n_fail++; $display("FAIL rst_data: sample %0d got %h want %h", m, got_at(m), exp_at(m));
        end
    endtask

    initial begin
        test_reset();
        test_single_symbol();
        test_back_pressure();
        test_overflow();
        test_mid_burst_deassert();
        test_resync();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
